piece_stamp: RTL and testbench

Writes the active tetromino into the board RAM once it locks, after checking that all four target cells are in bounds and empty. It runs under the same enable/complete handshake as the other board-RAM masters. The top-level FSM enables it before `row_clear` and muxes its RAM port onto the shared board RAM. It also reports a collision, which the game FSM uses for spawn-blocked / game-over detection.

---
 rtl/piece_stamp_pkg.sv | 53 +++++
 rtl/piece_stamp_coord_to_addr.sv | 12 +
 rtl/piece_stamp.sv | 186 ++++++++++++++++++
 tb/tb_piece_stamp.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/piece_stamp_pkg.sv
// Shared game package: board geometry, cell packing widths, block colours and the
// piece_stamp state encoding, plus helpers that pick one cell out of a packed piece.
package piece_stamp_pkg;

    localparam int BOARD_W = 10;
    localparam int BOARD_H = 25;
    localparam int X_W     = 5;
    localparam int Y_W     = 6;
    localparam int COLOR_W = 6;
    localparam int ADDR_W  = 8;
    localparam int STATE_W = 3;

    localparam logic [COLOR_W-1:0] EMPTY_BLK = 6'd0;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_C_ADDR = 3'd1;
    localparam logic [STATE_W-1:0] ST_C_WAIT = 3'd2;
    localparam logic [STATE_W-1:0] ST_C_READ = 3'd3;
    localparam logic [STATE_W-1:0] ST_W_ADDR = 3'd4;
    localparam logic [STATE_W-1:0] ST_W_WREN = 3'd5;
    localparam logic [STATE_W-1:0] ST_W_END  = 3'd6;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = ST_IDLE,
        C_ADDR = ST_C_ADDR,
        C_WAIT = ST_C_WAIT,
        C_READ = ST_C_READ,
        W_ADDR = ST_W_ADDR,
        W_WREN = ST_W_WREN,
        W_END  = ST_W_END,
        DONE   = ST_DONE
    } state_t;

    function automatic logic [X_W-1:0] cell_x_sel(input logic [4*X_W-1:0] xs, input logic [1:0] idx);
        case (idx)
            2'd0:    cell_x_sel = xs[4:0];
            2'd1:    cell_x_sel = xs[9:5];
            2'd2:    cell_x_sel = xs[14:10];
            default: cell_x_sel = xs[19:15];
        endcase
    endfunction

    function automatic logic [Y_W-1:0] cell_y_sel(input logic [4*Y_W-1:0] ys, input logic [1:0] idx);
        case (idx)
            2'd0:    cell_y_sel = ys[5:0];
            2'd1:    cell_y_sel = ys[11:6];
            2'd2:    cell_y_sel = ys[17:12];
            default: cell_y_sel = ys[23:18];
        endcase
    endfunction

endpackage

// File: rtl/piece_stamp_coord_to_addr.sv
// Board coordinate to linear board-RAM address: addr = y*BOARD_W + x, 8-bit unsigned.
module coord_to_addr #(
    parameter int BOARD_W = 10
) (
    input  logic [4:0] x,
    input  logic [5:0] y,
    output logic [7:0] addr
);

    assign addr = ({2'b00, y} * 8'(BOARD_W)) + {3'b000, x};

endmodule

// File: rtl/piece_stamp.sv
// Locks the active tetromino into the board RAM after bounds/occupancy checks on all four cells.
// Optional erase mode (colour 0 clears the cells) is enabled by defining PIECE_STAMP_ERASE_EN.
module piece_stamp #(
    parameter int BOARD_W = piece_stamp_pkg::BOARD_W,
    parameter int BOARD_H = piece_stamp_pkg::BOARD_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [19:0] cell_x,
    input  logic [23:0] cell_y,
    input  logic [5:0]  color,
    input  logic [5:0]  ram_Q,
    output logic [7:0]  ram_addr,
    output logic [5:0]  ram_data,
    output logic        ram_wren,
    output logic        collision,
    output logic        complete
);

    import piece_stamp_pkg::*;

    localparam logic [X_W-1:0] X_LIM = X_W'(BOARD_W);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(BOARD_H);

    state_t              state_r, state_s;
    logic [1:0]          idx_r, idx_s;
    logic [4*X_W-1:0]    xs_r, xs_s;
    logic [4*Y_W-1:0]    ys_r, ys_s;
    logic [COLOR_W-1:0]  color_r, color_s;
    logic [ADDR_W-1:0]   ram_addr_r, addr_s;
    logic [COLOR_W-1:0]  ram_data_r, data_s;
    logic                ram_wren_r, wren_s;
    logic                collision_r, coll_s;
    logic                complete_r, comp_s;

    logic [X_W-1:0]      cur_x_s;
    logic [Y_W-1:0]      cur_y_s;
    logic [ADDR_W-1:0]   cell_addr_s;
    logic                oob_s;
    logic                erase_s;
    logic                illegal_s;

    assign cur_x_s = cell_x_sel(xs_r, idx_r);
    assign cur_y_s = cell_y_sel(ys_r, idx_r);
    assign oob_s   = (cur_x_s >= X_LIM) || (cur_y_s >= Y_LIM);

    // Erase mode skips occupancy; without it a colour-0 request is rejected outright
`ifdef PIECE_STAMP_ERASE_EN
    assign erase_s   = (color_r == EMPTY_BLK);
    assign illegal_s = 1'b0;
`else
    assign erase_s   = 1'b0;
    assign illegal_s = (color_r == EMPTY_BLK);
`endif

    coord_to_addr #(.BOARD_W(BOARD_W)) u_coord_to_addr (
        .x    (cur_x_s),
        .y    (cur_y_s),
        .addr (cell_addr_s)
    );

    // Next-state and next-output logic for the check-then-write sequence
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        xs_s    = xs_r;
        ys_s    = ys_r;
        color_s = color_r;
        addr_s  = ram_addr_r;
        data_s  = ram_data_r;
        wren_s  = ram_wren_r;
        coll_s  = collision_r;
        comp_s  = complete_r;
        if (!enable) begin
            state_s = IDLE;
            idx_s   = 2'd0;
            addr_s  = 8'd0;
            data_s  = 6'd0;
            wren_s  = 1'b0;
            coll_s  = 1'b0;
            comp_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    xs_s    = cell_x;
                    ys_s    = cell_y;
                    color_s = color;
                    idx_s   = 2'd0;
                    state_s = C_ADDR;
                end
                C_ADDR: begin
                    if (illegal_s || oob_s) begin
                        coll_s  = 1'b1;
                        comp_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        addr_s  = cell_addr_s;
                        state_s = C_WAIT;
                    end
                end
                C_WAIT: begin
                    state_s = C_READ;
                end
                C_READ: begin
                    if (!erase_s && (ram_Q != EMPTY_BLK)) begin
                        coll_s  = 1'b1;
                        comp_s  = 1'b1;
                        state_s = DONE;
                    end else if (idx_r == 2'd3) begin
                        idx_s   = 2'd0;
                        state_s = W_ADDR;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = C_ADDR;
                    end
                end
                W_ADDR: begin
                    addr_s  = cell_addr_s;
                    data_s  = color_r;
                    state_s = W_WREN;
                end
                W_WREN: begin
                    wren_s  = 1'b1;
                    state_s = W_END;
                end
                W_END: begin
                    wren_s = 1'b0;
                    if (idx_r == 2'd3) begin
                        comp_s  = 1'b1;
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 2'd1;
                        state_s = W_ADDR;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = IDLE;
                    idx_s   = 2'd0;
                    addr_s  = 8'd0;
                    data_s  = 6'd0;
                    wren_s  = 1'b0;
                    coll_s  = 1'b0;
                    comp_s  = 1'b0;
                end
            endcase
        end
    end

    // State, latched piece and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            idx_r       <= 2'd0;
            xs_r        <= 20'd0;
            ys_r        <= 24'd0;
            color_r     <= 6'd0;
            ram_addr_r  <= 8'd0;
            ram_data_r  <= 6'd0;
            ram_wren_r  <= 1'b0;
            collision_r <= 1'b0;
            complete_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            xs_r        <= xs_s;
            ys_r        <= ys_s;
            color_r     <= color_s;
            ram_addr_r  <= addr_s;
            ram_data_r  <= data_s;
            ram_wren_r  <= wren_s;
            collision_r <= coll_s;
            complete_r  <= comp_s;
        end
    end

    assign ram_addr  = ram_addr_r;
    assign ram_data  = ram_data_r;
    assign ram_wren  = ram_wren_r;
    assign collision = collision_r;
    assign complete  = complete_r;

endmodule

// File: tb/tb_piece_stamp.sv
// Scoreboard bench for piece_stamp: directed pieces against a registered-read board RAM model.
module tb_piece_stamp;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [19:0] cell_x;
    logic [23:0] cell_y;
    logic [5:0]  color;
    logic [5:0]  ram_Q;
    logic [7:0]  ram_addr;
    logic [5:0]  ram_data;
    logic        ram_wren;
    logic        collision;
    logic        complete;

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    logic [5:0] mem [256];

    typedef struct {
        bit         is_wr;
        logic [7:0] addr;
        logic [5:0] data;
        bit         coll;
        int         edge_n;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_ev;
    bit  prev_comp = 1'b0;

    piece_stamp dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .cell_x    (cell_x),
        .cell_y    (cell_y),
        .color     (color),
        .ram_Q     (ram_Q),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .collision (collision),
        .complete  (complete)
    );

    always #5 clk = ~clk;

    // Board RAM: registered read, synchronous write
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_Q <= mem[ram_addr];
    end

    // Edge number within the current request (1 = latch edge)
    always @(posedge clk) begin
        if (enable) edge_cnt <= edge_cnt + 1;
        else        edge_cnt <= 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop the expected write/completion whenever the DUT presents one
    always @(negedge clk) begin
        if (ram_wren) begin
            if (exp_q.size() == 0 || !exp_q[0].is_wr) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_write: got addr %0d data %0d at edge %0d, expected none", ram_addr, ram_data, edge_cnt);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("wr_addr", 32'(ram_addr), 32'(mon_ev.addr));
                chk("wr_data", 32'(ram_data), 32'(mon_ev.data));
                chk("wr_edge", 32'(edge_cnt), 32'(mon_ev.edge_n));
            end
        end
        if (complete && !prev_comp) begin
            if (exp_q.size() == 0 || exp_q[0].is_wr) begin
                n_vec++; n_err++;
                $display("FAIL unexpected_complete: got complete at edge %0d coll %0d, expected none", edge_cnt, collision);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("collision", 32'(collision), 32'(mon_ev.coll));
                chk("done_edge", 32'(edge_cnt), 32'(mon_ev.edge_n));
            end
        end
        prev_comp = complete;
    end

    function automatic logic [19:0] px(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [23:0] py(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic exp_wr(input int a, input int d, input int e);
        ev_t ev;
        ev.is_wr = 1'b1; ev.addr = 8'(a); ev.data = 6'(d); ev.coll = 1'b0; ev.edge_n = e;
        exp_q.push_back(ev);
    endtask

    task automatic exp_done(input bit c, input int e);
        ev_t ev;
        ev.is_wr = 1'b0; ev.addr = 8'd0; ev.data = 6'd0; ev.coll = c; ev.edge_n = e;
        exp_q.push_back(ev);
    endtask

    task automatic exp_four_writes(input int a0, input int a1, input int a2, input int a3, input int d);
        exp_wr(a0, d, 15);
        exp_wr(a1, d, 18);
        exp_wr(a2, d, 21);
        exp_wr(a3, d, 24);
        exp_done(1'b0, 25);
    endtask

    task automatic clear_board();
        for (int i = 0; i < 256; i++) mem[i] = 6'd0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wren"}, 32'(ram_wren), 32'd0);
        chk({tag, "_complete"}, 32'(complete), 32'd0);
        chk({tag, "_collision"}, 32'(collision), 32'd0);
        chk({tag, "_addr"}, 32'(ram_addr), 32'd0);
        chk({tag, "_data"}, 32'(ram_data), 32'd0);
    endtask

    // One request; stop_at > 0 drops enable right after that edge instead of waiting for complete
    task automatic run_piece(input logic [19:0] cx, input logic [23:0] cy, input logic [5:0] col, input int stop_at);
        cell_x = cx; cell_y = cy; color = col; enable = 1'b1;
        @(negedge clk);
        cell_x = 20'hFFFFF; cell_y = 24'hFFFFFF; color = 6'd63;
        if (stop_at > 0) begin
            for (int i = 0; i < 40 && edge_cnt < stop_at; i++) @(negedge clk);
            chk("stop_edge_reached", 32'(edge_cnt), 32'(stop_at));
        end else begin
            for (int i = 0; i < 40 && !complete; i++) @(negedge clk);
            chk("complete_seen", 32'(complete), 32'd1);
        end
        enable = 1'b0;
        @(negedge clk);
        chk_idle_outputs("release");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    logic [19:0] sq_x;
    logic [23:0] sq_y;

    initial begin
        reset = 1'b1; enable = 1'b0; cell_x = 20'd0; cell_y = 24'd0; color = 6'd0;
        clear_board();
        sq_x = px(4, 5, 4, 5);
        sq_y = py(0, 0, 1, 1);
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // Normal lock onto an empty board
        exp_four_writes(4, 5, 14, 15, 3);
        run_piece(sq_x, sq_y, 6'd3, 0);
        chk("mem4", 32'(mem[4]), 32'd3);
        chk("mem5", 32'(mem[5]), 32'd3);
        chk("mem14", 32'(mem[14]), 32'd3);
        chk("mem15", 32'(mem[15]), 32'd3);

        // Cell 3 occupied
        clear_board();
        mem[15] = 6'd2;
        exp_done(1'b1, 13);
        run_piece(sq_x, sq_y, 6'd3, 0);
        chk("occ_untouched4", 32'(mem[4]), 32'd0);
        chk("occ_keep15", 32'(mem[15]), 32'd2);

        // Cell 2 below the board
        clear_board();
        exp_done(1'b1, 8);
        run_piece(sq_x, py(0, 0, 25, 1), 6'd3, 0);
        chk("oob_untouched4", 32'(mem[4]), 32'd0);

        // Cell 0 right of the board
        exp_done(1'b1, 2);
        run_piece(px(10, 5, 4, 5), sq_y, 6'd3, 0);

        // Duplicate cells and the highest address
        exp_four_writes(243, 243, 249, 0, 5);
        run_piece(px(3, 3, 9, 0), py(24, 24, 24, 0), 6'd5, 0);
        chk("mem243", 32'(mem[243]), 32'd5);
        chk("mem249", 32'(mem[249]), 32'd5);

        // Abort right after the first write strobe
        clear_board();
        exp_wr(4, 3, 15);
        run_piece(sq_x, sq_y, 6'd3, 15);
        chk("abort_mem4", 32'(mem[4]), 32'd3);
        chk("abort_mem5", 32'(mem[5]), 32'd0);

        // Colour 0
        clear_board();
        mem[5] = 6'd7;
`ifdef PIECE_STAMP_ERASE_EN
        mem[4] = 6'd7; mem[14] = 6'd7; mem[15] = 6'd7;
        exp_four_writes(4, 5, 14, 15, 0);
        run_piece(sq_x, sq_y, 6'd0, 0);
        chk("erase_mem4", 32'(mem[4]), 32'd0);
        chk("erase_mem5", 32'(mem[5]), 32'd0);
        chk("erase_mem15", 32'(mem[15]), 32'd0);
`else
        exp_done(1'b1, 2);
        run_piece(sq_x, sq_y, 6'd0, 0);
        chk("illegal_keep5", 32'(mem[5]), 32'd7);
`endif

        // Reset while the first write strobe is being raised, then a fresh run
        clear_board();
        cell_x = sq_x; cell_y = sq_y; color = 6'd3; enable = 1'b1;
        for (int i = 0; i < 40 && edge_cnt < 14; i++) @(negedge clk);
        chk("rst_edge_reached", 32'(edge_cnt), 32'd14);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_mem4", 32'(mem[4]), 32'd0);
        exp_four_writes(4, 5, 14, 15, 3);
        run_piece(sq_x, sq_y, 6'd3, 0);
        chk("fresh_mem14", 32'(mem[14]), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
